// File: rtl/btn_debounce.sv
// Per-channel button conditioner: two-flop synchronizer, stability counter,
// registered level, one-cycle press/release pulses and a press-toggled latch.
module btn_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Btn,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic [WIDTH-1:0] btn_toggle
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] press_q;
    logic [WIDTH-1:0] press_d;
    logic [WIDTH-1:0] release_q;
    logic [WIDTH-1:0] release_d;
    logic [WIDTH-1:0] toggle_q;
    logic [WIDTH-1:0] toggle_d;

    // Two-stage synchronizer; nothing may sit between the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= Btn;
            sync2_q <= sync1_q;
        end
    end

    // Next-state: a deviation must persist DEBOUNCE_CYCLES samples before it is accepted.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        toggle_d  = toggle_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                // Any agreeing sample restarts the count, which rejects bounce.
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i]   = sync2_q[i];
                cnt_d[i]     = CNT_ZERO;
                press_d[i]   = sync2_q[i];
                release_d[i] = ~sync2_q[i];
                if (sync2_q[i]) begin
                    toggle_d[i] = ~toggle_q[i];
                end else begin
                    toggle_d[i] = toggle_q[i];
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            toggle_q  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_toggle  = toggle_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with DEBOUNCE_CYCLES = 16: stimulus queues
// expected pulse events, a negedge monitor pops and compares each pulse.
module tb_btn_debounce;

    logic       clk;
    logic       rst;
    logic [7:0] Btn;
    logic [7:0] btn_level;
    logic [7:0] btn_press;
    logic [7:0] btn_release;
    logic [7:0] btn_toggle;

    typedef struct {
        int         cyc;
        logic [7:0] press;
        logic [7:0] rel;
        logic [7:0] level;
        logic [7:0] tog;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   failures;

    btn_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk),
        .rst(rst),
        .Btn(Btn),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_toggle(btn_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge count, used as the time base for expected pulse cycles.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive(input logic [7:0] v);
        @(posedge clk);
        #1;
        Btn = v;
    endtask

    // Pulse is expected 1 (sync to E0) + 17 (latency) posedges after the drive point.
    task automatic push(input logic [7:0] p, input logic [7:0] r,
                        input logic [7:0] l, input logic [7:0] t);
        exp_t e;
        e.cyc = cyc + 18; e.press = p; e.rel = r; e.level = l; e.tog = t;
        q.push_back(e);
    endtask

    task automatic drive_exp(input logic [7:0] v, input logic [7:0] p, input logic [7:0] r,
                             input logic [7:0] l, input logic [7:0] t);
        drive(v);
        push(p, r, l, t);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && ((btn_press | btn_release) != 8'h00)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: press=%0h release=%0h expected none (cycle %0d)",
                         btn_press, btn_release, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("press", {24'd0, btn_press}, {24'd0, e.press});
                chk("release", {24'd0, btn_release}, {24'd0, e.rel});
                chk("level", {24'd0, btn_level}, {24'd0, e.level});
                chk("toggle", {24'd0, btn_toggle}, {24'd0, e.tog});
            end
        end
    end

    initial begin
        logic [7:0] v;
        cyc      = 0;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        Btn      = 8'h00;
        idle(3);
        #1;
        chk("rst_level", {24'd0, btn_level}, 32'd0);
        chk("rst_press", {24'd0, btn_press}, 32'd0);
        chk("rst_release", {24'd0, btn_release}, 32'd0);
        chk("rst_toggle", {24'd0, btn_toggle}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // Simultaneous press on several channels, twice.
        drive_exp(8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5); idle(25);
        drive_exp(8'h00, 8'h00, 8'hA5, 8'h00, 8'hA5); idle(25);
        drive_exp(8'hA5, 8'hA5, 8'h00, 8'hA5, 8'h00); idle(25);
        drive_exp(8'h00, 8'h00, 8'hA5, 8'h00, 8'h00); idle(25);

        // Clean press/release on channel 0.
        drive_exp(8'h01, 8'h01, 8'h00, 8'h01, 8'h01); idle(25);
        drive_exp(8'h00, 8'h00, 8'h01, 8'h00, 8'h01); idle(25);

        // Channel 3 bounces with 5-cycle runs, then settles high.
        for (int k = 0; k < 20; k++) begin
            v = 8'h00;
            v[3] = ((k % 2) == 0);
            drive(v);
            idle(4);
        end
        drive_exp(8'h08, 8'h08, 8'h00, 8'h08, 8'h09); idle(25);
        drive_exp(8'h00, 8'h00, 8'h08, 8'h00, 8'h09); idle(25);

        // Channel 5 high for 15 samples: rejected.
        drive(8'h20);
        idle(14);
        drive(8'h00);
        idle(25);
        #1;
        chk("short_level", {24'd0, btn_level}, 32'd0);
        chk("short_toggle", {24'd0, btn_toggle}, 32'h09);

        // Channel 5 high for 16 samples: accepted, then released.
        drive_exp(8'h20, 8'h20, 8'h00, 8'h20, 8'h29);
        idle(15);
        drive_exp(8'h00, 8'h00, 8'h20, 8'h00, 8'h29);
        idle(25);

        // Channel 1 bounces in 3-cycle runs while channel 2 presses cleanly.
        for (int k = 0; k < 30; k++) begin
            v = 8'h04;
            v[1] = (((k / 3) % 2) == 0);
            if (k == 0) drive_exp(v, 8'h04, 8'h00, 8'h04, 8'h2D);
            else        drive(v);
        end
        drive_exp(8'h00, 8'h00, 8'h04, 8'h00, 8'h2D); idle(25);

        // Reset mid-count with a stable level present.
        drive_exp(8'h0F, 8'h0F, 8'h00, 8'h0F, 8'h22); idle(25);
        drive(8'hFF);
        idle(8);
        #3;
        rst = 1'b1;
        #1;
        chk("async_level", {24'd0, btn_level}, 32'd0);
        chk("async_press", {24'd0, btn_press}, 32'd0);
        chk("async_release", {24'd0, btn_release}, 32'd0);
        chk("async_toggle", {24'd0, btn_toggle}, 32'd0);
        idle(3);
        #1;
        chk("held_rst_level", {24'd0, btn_level}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(8'hFF, 8'h00, 8'hFF, 8'hFF);
        idle(25);

        chk("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
